// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and op code in, result, flags and handshake out.
interface seq_alu_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] BusW;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, BusA, BusB, ALUCtrl,
        input  BusW, Zero, Negative, Carry, Overflow, Busy, Done
    );

    modport slave (
        input  Start, BusA, BusB, ALUCtrl,
        output BusW, Zero, Negative, Carry, Overflow, Busy, Done
    );
endinterface

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add unsigned multiply, with a Start/Busy/Done handshake and registered N/Z/C/V flags.
module seq_alu #(
    parameter  int WIDTH = 64,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     CLK,
    input  logic     Reset,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_LSL = 4'h3;
    localparam logic [3:0] OP_LSR = 4'h4;
    localparam logic [3:0] OP_ASR = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_PSB = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} aluState_t;

    aluState_t          state;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [3:0]         opReg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [SHW-1:0]     count;

    logic [WIDTH-1:0]   bOp;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH-1:0]   resNext;
    logic               carryNext;
    logic               ovfNext;
    logic               commit;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        bOp       = (opReg == OP_SUB) ? ~bReg : bReg;
        sum       = {1'b0, aReg} + {1'b0, bOp} + {{WIDTH{1'b0}}, opReg == OP_SUB};
        shamt     = bReg[SHW-1:0];
        mulNext   = acc + (bReg[0] ? mcand : '0);
        resNext   = '0;
        carryNext = 1'b0;
        ovfNext   = 1'b0;
        commit    = (state == EXEC) || (state == MUL && count == SHW'(WIDTH - 1));

        if (state == MUL) begin
            resNext = mulNext[WIDTH-1:0];
        end else begin
            case (opReg)
                OP_AND: resNext = aReg & bReg;
                OP_OR:  resNext = aReg | bReg;
                OP_LSL: resNext = aReg << shamt;
                OP_LSR: resNext = aReg >> shamt;
                OP_ASR: resNext = $unsigned($signed(aReg) >>> shamt);
                OP_PSB: resNext = bReg;
                OP_ADD, OP_SUB: begin
                    resNext   = sum[WIDTH-1:0];
                    carryNext = sum[WIDTH];
                    // SUB shares the adder with B inverted, so one overflow rule covers both.
                    ovfNext   = (aReg[WIDTH-1] == bOp[WIDTH-1]) && (sum[WIDTH-1] != aReg[WIDTH-1]);
                end
                default: resNext = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= IDLE;
            aReg         <= '0;
            bReg         <= '0;
            opReg        <= '0;
            acc          <= '0;
            mcand        <= '0;
            count        <= '0;
            bus.BusW     <= '0;
            bus.Zero     <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Carry    <= 1'b0;
            bus.Overflow <= 1'b0;
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b0;
        end else begin
            bus.Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        aReg     <= bus.BusA;
                        bReg     <= bus.BusB;
                        opReg    <= bus.ALUCtrl;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, bus.BusA};
                        count    <= '0;
                        bus.Busy <= 1'b1;
                        state    <= (bus.ALUCtrl == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: state <= IDLE;
                MUL: begin
                    // One multiplier bit per cycle: B walks right while the partial multiplicand walks left.
                    acc   <= mulNext;
                    mcand <= mcand << 1;
                    bReg  <= bReg >> 1;
                    count <= count + SHW'(1);
                    if (commit) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                bus.BusW     <= resNext;
                bus.Zero     <= (resNext == '0);
                bus.Negative <= resNext[WIDTH-1];
                bus.Carry    <= carryNext;
                bus.Overflow <= ovfNext;
                bus.Busy     <= 1'b0;
                bus.Done     <= 1'b1;
            end
        end
    end
endmodule
